// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - ROM bus, control-unit handshake and status bundle for instr_fetch
interface instr_fetch_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 9
);
  logic              Enable;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] IR;
  logic [DATA_W-1:0] DIN;
  logic              Run;
  logic              Done;
  logic [ADDR_W-1:0] PC;
  logic              Busy;
  logic              Halted;
  logic              Err;
  logic [7:0]        InstrCount;

  modport master (
    input  Enable, mem_data, Done,
    output mem_addr, IR, DIN, Run, PC, Busy, Halted, Err, InstrCount
  );

  modport slave (
    output Enable, mem_data, Done,
    input  mem_addr, IR, DIN, Run, PC, Busy, Halted, Err, InstrCount
  );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction-fetch sequencer feeding the processor control unit
module instr_fetch #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 9,
  parameter int TIMEOUT = 15
) (
  input logic           clk,
  input logic           Reset,
  instr_fetch_if.master bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_IMM, S_IMM_LAT, S_ISSUE, S_WAIT_DONE, S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] din_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_q;
  logic [7:0]        count_q;

  logic       pc_inc, ir_load, din_load, cnt_clr, cnt_inc, instr_done, err_set;
  logic [2:0] opcode;

  // Decode straight from the ROM output in LATCH, the same word being captured into IR.
  assign opcode = bus.mem_data[DATA_W-1 -: 3];

  always_comb begin
    state_d    = state_q;
    pc_inc     = 1'b0;
    ir_load    = 1'b0;
    din_load   = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    instr_done = 1'b0;
    err_set    = 1'b0;
    case (state_q)
      S_IDLE:    if (bus.Enable) state_d = S_FETCH;
      S_FETCH:   state_d = S_LATCH;
      S_LATCH: begin
        ir_load = 1'b1;
        pc_inc  = 1'b1;
        if (opcode[2])             state_d = S_HALT;
        else if (opcode == 3'b001) state_d = S_IMM;
        else                       state_d = S_ISSUE;
      end
      S_IMM:     state_d = S_IMM_LAT;
      S_IMM_LAT: begin
        din_load = 1'b1;
        pc_inc   = 1'b1;
        state_d  = S_ISSUE;
      end
      S_ISSUE: begin
        cnt_clr = 1'b1;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // Done takes priority over the final timeout count.
        if (bus.Done) begin
          instr_done = 1'b1;
          state_d    = bus.Enable ? S_FETCH : S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_set = 1'b1;
          state_d = S_HALT;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      din_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (pc_inc)     pc_q    <= pc_q + 1'b1;
      if (ir_load)    ir_q    <= bus.mem_data;
      if (din_load)   din_q   <= bus.mem_data;
      if (cnt_clr)    cnt_q   <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + 1'b1;
      if (err_set)    err_q   <= 1'b1;
      if (instr_done) count_q <= count_q + 8'd1;
    end
  end

  assign bus.mem_addr   = pc_q;
  assign bus.PC         = pc_q;
  assign bus.IR         = ir_q;
  assign bus.DIN        = din_q;
  assign bus.Run        = (state_q == S_ISSUE);
  assign bus.Busy       = (state_q != S_IDLE) && (state_q != S_HALT);
  assign bus.Halted     = (state_q == S_HALT);
  assign bus.Err        = err_q;
  assign bus.InstrCount = count_q;
endmodule
